// File: rtl/tt_pattern_gen_multi.sv
// tt_pattern_gen_multi: multi-channel up/down/LFSR/load test-pattern generator with prescaler.
// The selected channel drives uo_out/uio_out; uo_out mirrors ui_in while rst_n is low.
module tt_pattern_gen_multi #(
    parameter int               WIDTH       = 8,
    parameter int               NCH         = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] LFSR_TAPS   = 8'hB8,
    parameter int               PS_W        = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {M_UP, M_DOWN, M_LFSR, M_LOAD} mode_e;

    logic                   drive;
    mode_e                  mode;
    logic [1:0]             chan_sel;
    logic [2:0]             psel;
    logic                   rst_i;
    logic                   tick;
    logic                   unused_ok;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [PS_W-1:0]        ps_q, ps_d, mask;
    logic [WIDTH-1:0]       ch_q [NCH];
    logic [WIDTH-1:0]       ch_d [NCH];
    logic [WIDTH-1:0]       pad [4];
    logic [WIDTH-1:0]       sel_val;

    assign unused_ok = ena;
    assign drive     = ui_in[0];
    assign mode      = mode_e'(ui_in[2:1]);
    assign chan_sel  = ui_in[4:3];
    assign psel      = ui_in[7:5];

    // Assertion is immediate; release walks through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= (sync_q << 1) | SYNC_STAGES'(1);
    end
    assign rst_i = ~sync_q[SYNC_STAGES-1];

    assign mask = (PS_W'(1) << psel) - PS_W'(1);
    assign tick = (ps_q & mask) == mask;
    assign ps_d = rst_i ? '0 : ps_q + PS_W'(1);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_d[i] = ch_q[i];
            if (rst_i)     ch_d[i] = '0;
            else if (tick) ch_d[i] = mode == M_UP   ? ch_q[i] + WIDTH'(i + 1) :
                                     mode == M_DOWN ? ch_q[i] - WIDTH'(i + 1) :
                                     mode == M_LFSR ? (ch_q[i] == '0 ? WIDTH'(1) :
                                                       (ch_q[i] >> 1) ^ (ch_q[i][0] ? LFSR_TAPS : '0)) :
                                     (!drive && chan_sel == 2'(i)) ? uio_in : ch_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
            ch_q <= '{default: '0};
        end else begin
            ps_q <= ps_d;
            ch_q <= ch_d;
        end
    end

    // Channels beyond NCH read as zero.
    for (genvar j = 0; j < 4; j++) begin : g_pad
        if (j < NCH) begin : g_ch
            assign pad[j] = ch_q[j];
        end else begin : g_zero
            assign pad[j] = '0;
        end
    end
    assign sel_val = pad[chan_sel];

    assign uo_out  = !rst_n ? ui_in : (drive ? sel_val : uio_in);
    assign uio_out = drive ? sel_val : 8'h00;
    assign uio_oe  = (rst_n && drive) ? 8'hFF : 8'h00;
endmodule

// File: tb/tb_tt_pattern_gen_multi.sv
// tb_tt_pattern_gen_multi: vector table of {rst_n, inputs, expected pins}, one clock per vector.
// Built with NCH=3 so that chan_sel=3 selects a missing channel.
module tb_tt_pattern_gen_multi;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    typedef struct {
        logic       rn;
        logic [7:0] ui, uio, uo, uout, oe;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    tt_pattern_gen_multi #(.NCH(3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    function automatic void v(input logic rn, input logic [7:0] ui, uio, uo, uout, oe);
        vec_t t;
        t.rn = rn; t.ui = ui; t.uio = uio; t.uo = uo; t.uout = uout; t.oe = oe;
        tbl.push_back(t);
    endfunction

    function automatic void d1(input logic [7:0] ui, sel);
        v(1'b1, ui, 8'h00, sel, sel, 8'hFF);
    endfunction

    function automatic void rs(input logic [7:0] ui);
        v(1'b0, ui, 8'h00, ui, 8'h00, 8'h00);
    endfunction

    task automatic chk(input int idx, input string name, input logic [7:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s got %h expected %h", idx, name, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        // reset passthrough, then release and UP ch0 through a full wrap
        rs(8'hA5); rs(8'hA5);
        d1(8'h01, 8'h00); d1(8'h01, 8'h00);
        for (int k = 0; k <= 256; k++) d1(8'h01, 8'(k));
        // async reset mid-count clears channels before any edge
        v(1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00); rs(8'hA5);
        // UP ch2 steps by 3; chan_sel=3 reads zero
        d1(8'h11, 8'h00); d1(8'h11, 8'h00);
        d1(8'h11, 8'h00); d1(8'h11, 8'h03); d1(8'h11, 8'h06); d1(8'h11, 8'h09);
        d1(8'h19, 8'h00);
        // DOWN ch0 with psel=2
        rs(8'h00);
        d1(8'h43, 8'h00); d1(8'h43, 8'h00);
        for (int k = 0; k < 4; k++) d1(8'h43, 8'h00);
        for (int k = 0; k < 4; k++) d1(8'h43, 8'hFF);
        d1(8'h43, 8'hFE);
        // LFSR ch0 from zero
        rs(8'h00);
        d1(8'h05, 8'h00); d1(8'h05, 8'h00);
        d1(8'h05, 8'h00); d1(8'h05, 8'h01); d1(8'h05, 8'hB8); d1(8'h05, 8'h5C);
        d1(8'h05, 8'h2E); d1(8'h05, 8'h17); d1(8'h05, 8'hB3);
        // LOAD ch1, hold with drive=1, then UP ch1; ch0 untouched by the load
        rs(8'h00);
        v(1'b1, 8'h0E, 8'h7E, 8'h7E, 8'h00, 8'h00); v(1'b1, 8'h0E, 8'h7E, 8'h7E, 8'h00, 8'h00);
        v(1'b1, 8'h0E, 8'h7E, 8'h7E, 8'h00, 8'h00);
        v(1'b1, 8'h0E, 8'h3C, 8'h3C, 8'h00, 8'h00);
        v(1'b1, 8'h0F, 8'h55, 8'h3C, 8'h3C, 8'hFF); v(1'b1, 8'h0F, 8'h55, 8'h3C, 8'h3C, 8'hFF);
        d1(8'h09, 8'h3C); d1(8'h09, 8'h3E); d1(8'h09, 8'h40);
        d1(8'h01, 8'h03);
        // DOWN ch1 wraps 0 -> FE
        rs(8'h00);
        d1(8'h0B, 8'h00); d1(8'h0B, 8'h00);
        d1(8'h0B, 8'h00); d1(8'h0B, 8'hFE); d1(8'h0B, 8'hFC);
        // psel changes apply next cycle without clearing the prescaler
        rs(8'h00);
        d1(8'h21, 8'h00); d1(8'h21, 8'h00);
        d1(8'h21, 8'h00); d1(8'h21, 8'h00); d1(8'h01, 8'h01); d1(8'h41, 8'h02);
        d1(8'h41, 8'h03); d1(8'h41, 8'h03); d1(8'h41, 8'h03); d1(8'h41, 8'h03);
        d1(8'h41, 8'h04);

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rn; ui_in = tbl[i].ui; uio_in = tbl[i].uio;
            exp_q.push_back(tbl[i]);
            #1;
            e = exp_q.pop_front();
            chk(i, "uo_out", uo_out, e.uo);
            chk(i, "uio_out", uio_out, e.uout);
            chk(i, "uio_oe", uio_oe, e.oe);
            @(posedge clk); #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
